ones_accum_sat: RTL and testbench

- Parametrised saturating ones-counter, the successor to the 3-bit single-input ones counter.
- Each valid cycle it accepts IN_W bits, adds or subtracts their popcount to a CNT_W-bit count, and clamps at configurable limits.
- Adds a sticky upper-saturation state, a synchronous clear, an up/down mode and a registered threshold-crossing pulse.
- Sits between bit-stream sources (error/event flags) and status/interrupt logic.

---
 rtl/ones_accum_sat.sv | 94 +++++++++
 tb/tb_ones_accum_sat.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ones_accum_sat.sv
// Saturating up/down popcount accumulator with a sticky upper limit.
// Emits a registered one-cycle pulse when the count first reaches THRESH.
module ones_accum_sat #(
    parameter int unsigned IN_W   = 4,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned MAX    = 200,
    parameter int unsigned THRESH = 100
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_data,
    input  logic            down,
    output logic [CNT_W-1:0] count,
    output logic            sat,
    output logic            zero,
    output logic            thr_hit
);

    localparam int unsigned PW = $clog2(IN_W + 1);
    // Wide enough for count+pc even when pc is wider than the counter.
    localparam int unsigned AW = ((CNT_W > PW) ? CNT_W : PW) + 1;

    typedef enum logic {
        COUNT = 1'b0,
        SAT   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             thr_q, thr_d;
    logic [PW-1:0]    pc;
    logic [AW-1:0]    sum, diff;

    always_comb begin
        pc = '0;
        for (int i = 0; i < int'(IN_W); i++) begin
            pc = pc + PW'(in_data[i]);
        end
    end

    assign sum  = AW'(count_q) + AW'(pc);
    assign diff = AW'(count_q) - AW'(pc);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            COUNT: begin
                if (in_valid && !down) begin
                    if (sum >= AW'(MAX)) begin
                        count_d = CNT_W'(MAX);
                        state_d = SAT;
                    end else begin
                        count_d = sum[CNT_W-1:0];
                    end
                end else if (in_valid && down) begin
                    if (AW'(pc) > AW'(count_q)) count_d = '0;
                    else count_d = diff[CNT_W-1:0];
                end
            end
            SAT: count_d = CNT_W'(MAX);
            default: begin
                state_d = COUNT;
                count_d = '0;
            end
        endcase
        if (clear) begin
            state_d = COUNT;
            count_d = '0;
        end
        thr_d = !clear && (count_q < CNT_W'(THRESH))
                && (count_d >= CNT_W'(THRESH));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= COUNT;
            count_q <= '0;
            thr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            thr_q   <= thr_d;
        end
    end

    assign count   = count_q;
    assign sat     = (state_q == SAT);
    assign zero    = (count_q == '0);
    assign thr_hit = thr_q;

endmodule

// File: tb/tb_ones_accum_sat.sv
// Directed bench for ones_accum_sat: vector table plus reset and
// narrow-configuration sequences.
module tb_ones_accum_sat;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0, in_valid = 1'b0, down = 1'b0;
    logic [3:0] in_data = '0;
    logic [7:0] count;
    logic       sat, zero, thr_hit;

    logic       s_clear = 1'b0, s_valid = 1'b0, s_down = 1'b0;
    logic [0:0] s_data = '0;
    logic [2:0] s_count;
    logic       s_sat, s_zero, s_thr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ones_accum_sat #(.IN_W(4), .CNT_W(8), .MAX(200), .THRESH(100)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .down(down),
        .count(count), .sat(sat), .zero(zero), .thr_hit(thr_hit)
    );

    ones_accum_sat #(.IN_W(1), .CNT_W(3), .MAX(7), .THRESH(4)) dut_s (
        .clk(clk), .reset_n(reset_n), .clear(s_clear),
        .in_valid(s_valid), .in_data(s_data), .down(s_down),
        .count(s_count), .sat(s_sat), .zero(s_zero), .thr_hit(s_thr)
    );

    typedef struct {
        logic       clr;
        logic       vld;
        logic       dn;
        logic [3:0] dat;
        int         cnt;
        logic       st;
        logic       zr;
        logic       th;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic clr, input logic vld, input logic dn,
                       input logic [3:0] dat, input int cnt,
                       input logic st, input logic th);
        vec_t v;
        v.clr = clr; v.vld = vld; v.dn = dn; v.dat = dat;
        v.cnt = cnt; v.st = st; v.zr = (cnt == 0); v.th = th;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        // up-count to threshold, then to saturation
        for (int i = 1; i <= 24; i++) add(0, 1, 0, 4'hF, 4 * i, 0, 0);
        add(0, 1, 0, 4'hF, 100, 0, 1);
        add(0, 1, 0, 4'hF, 104, 0, 0);
        for (int i = 1; i <= 23; i++) add(0, 1, 0, 4'hF, 104 + 4 * i, 0, 0);
        add(0, 1, 0, 4'hF, 200, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 1, 4'hF, 200, 1, 0);
        add(1, 0, 0, 4'h0, 0, 0, 0);
        // down floor and re-arm
        for (int i = 1; i <= 24; i++) add(0, 1, 0, 4'hF, 4 * i, 0, 0);
        add(0, 1, 0, 4'hF, 100, 0, 1);
        add(0, 1, 0, 4'h3, 102, 0, 0);
        add(0, 1, 1, 4'h7, 99, 0, 0);
        for (int i = 1; i <= 24; i++) add(0, 1, 1, 4'hF, 99 - 4 * i, 0, 0);
        add(0, 1, 1, 4'hF, 0, 0, 0);
        for (int i = 1; i <= 24; i++) add(0, 1, 0, 4'hF, 4 * i, 0, 0);
        add(0, 1, 0, 4'hF, 100, 0, 1);
        // clear versus valid collision at 50
        add(1, 0, 0, 4'h0, 0, 0, 0);
        for (int i = 1; i <= 12; i++) add(0, 1, 0, 4'hF, 4 * i, 0, 0);
        add(0, 1, 0, 4'h3, 50, 0, 0);
        add(1, 1, 0, 4'hF, 0, 0, 0);
        // gaps and zero popcount
        add(0, 1, 0, 4'hF, 4, 0, 0);
        add(0, 0, 0, 4'hF, 4, 0, 0);
        add(0, 1, 0, 4'h0, 4, 0, 0);
        add(0, 0, 1, 4'hF, 4, 0, 0);

        // reset held across edges
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", int'(count), 0);
        check("rst_zero", int'(zero), 1);
        check("rst_sat", int'(sat), 0);
        check("rst_thr", int'(thr_hit), 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_count", int'(count), 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            clear = vecs[i].clr; in_valid = vecs[i].vld;
            down = vecs[i].dn; in_data = vecs[i].dat;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_count", i), int'(count), vecs[i].cnt);
            check($sformatf("v%0d_sat", i), int'(sat), int'(vecs[i].st));
            check($sformatf("v%0d_zero", i), int'(zero), int'(vecs[i].zr));
            check($sformatf("v%0d_thr", i), int'(thr_hit), int'(vecs[i].th));
        end
        @(negedge clk);
        clear = 0; in_valid = 0; down = 0; in_data = '0;

        // narrow instance: 7 ones saturate a 3-bit counter
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("s%0d_count", i), int'(s_count), (i > 7) ? 7 : i);
            check($sformatf("s%0d_sat", i), int'(s_sat), int'(i >= 7));
            check($sformatf("s%0d_thr", i), int'(s_thr), int'(i == 4));
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_clear = 1'b1;
        @(posedge clk);
        #1;
        check("s_clr_count", int'(s_count), 0);
        check("s_clr_sat", int'(s_sat), 0);
        check("s_clr_zero", int'(s_zero), 1);
        @(negedge clk) s_clear = 1'b0;

        // asynchronous reset between edges
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'hF;
        @(posedge clk);
        #1;
        check("pre_async_count", int'(count), 8);
        #2 reset_n = 1'b0;
        #1;
        check("async_count", int'(count), 0);
        check("async_zero", int'(zero), 1);
        check("async_sat", int'(sat), 0);
        check("async_thr", int'(thr_hit), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
